// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared widths, FSM states and byte helper for the byte-serial memory
package mem_bus_pkg;

  localparam int BEATS_PER_WORD = 4;
  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int LAT_CNT_W      = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_ACCESS,
    ST_RDATA,
    ST_DONE
  } mem_state_t;

  // Byte streams arrive LSB first, so each new byte enters at the top of the word.
  function automatic logic [WORD_W-1:0] shift_in_byte(input logic [WORD_W-1:0] word,
                                                      input logic [BYTE_W-1:0] b);
    return {b, word[WORD_W-1:BYTE_W]};
  endfunction

endpackage

// File: rtl/word_ram.sv
// rtl/word_ram.sv - single-port DEPTH x 32 synchronous word array with registered read data
module word_ram
  import mem_bus_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_rdata;

  // Contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
    r_rdata <= r_mem[i_idx];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/byte_serial_mem.sv
// rtl/byte_serial_mem.sv - byte-serial front end: 4-beat address/data collection, timed word access, 4-beat read return
module byte_serial_mem
  import mem_bus_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ReadMem,
  input  logic              WriteMem,
  input  logic [BYTE_W-1:0] Addr,
  input  logic [BYTE_W-1:0] wData,
  output logic [BYTE_W-1:0] rData,
  output logic              Ready,
  output logic              Busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0]           BEAT_LAST = 2'(BEATS_PER_WORD - 1);
  localparam logic [LAT_CNT_W-1:0] LAT_LAST  = LAT_CNT_W'(LATENCY - 1);

  mem_state_t r_state;
  mem_state_t w_next_state;

  logic [1:0]           r_beat;
  logic [LAT_CNT_W-1:0] r_lat;
  logic                 r_is_write;
  logic [WORD_W-1:0]    r_addr;
  logic [WORD_W-1:0]    r_wdata;
  logic [WORD_W-1:0]    r_rdata;

  logic              w_beat_last;
  logic              w_lat_last;
  logic              w_start;
  logic              w_ram_we;
  logic              w_rd_load;
  logic [WORD_W-1:0] w_addr_full;
  logic [29:0]       w_word_full;
  logic [IDX_W-1:0]  w_ram_idx;
  logic [WORD_W-1:0] w_ram_rdata;
  logic              w_unused_bits;

  assign w_beat_last = (r_beat == BEAT_LAST);
  assign w_lat_last  = (r_lat == LAT_LAST);

  // The final address byte is forwarded straight to the array so a one-cycle
  // access still sees its read data in the same (only) ACCESS cycle.
  assign w_addr_full   = (r_state == ST_ADDR && w_beat_last) ? shift_in_byte(r_addr, Addr) : r_addr;
  assign w_word_full   = w_addr_full[WORD_W-1:2] % 30'(DEPTH);
  assign w_ram_idx     = w_word_full[IDX_W-1:0];
  assign w_unused_bits = ^{w_addr_full[1:0], w_word_full[29:IDX_W]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_ram_we     = 1'b0;
    w_rd_load    = 1'b0;
    rData        = '0;
    Ready        = 1'b0;
    Busy         = 1'b1;
    case (r_state)
      ST_IDLE: begin
        Busy = 1'b0;
        if (ReadMem || WriteMem) begin
          w_start      = 1'b1;
          w_next_state = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (w_beat_last) begin
          w_next_state = r_is_write ? ST_WDATA : ST_ACCESS;
        end
      end
      ST_WDATA: begin
        if (w_beat_last) begin
          w_next_state = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (w_lat_last) begin
          if (r_is_write) begin
            w_ram_we     = 1'b1;
            w_next_state = ST_DONE;
          end else begin
            w_rd_load    = 1'b1;
            w_next_state = ST_RDATA;
          end
        end
      end
      ST_RDATA: begin
        rData = r_rdata[BYTE_W-1:0];
        if (w_beat_last) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        Ready        = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Beat counter starts at 1 because address byte 0 is taken in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beat     <= '0;
      r_lat      <= '0;
      r_is_write <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_is_write <= WriteMem;
            r_addr     <= shift_in_byte(r_addr, Addr);
            r_beat     <= 2'd1;
          end
        end
        ST_ADDR: begin
          r_addr <= shift_in_byte(r_addr, Addr);
          r_beat <= r_beat + 2'd1;
        end
        ST_WDATA: begin
          r_wdata <= shift_in_byte(r_wdata, wData);
          r_beat  <= r_beat + 2'd1;
        end
        ST_ACCESS: begin
          r_lat <= w_lat_last ? '0 : r_lat + LAT_CNT_W'(1);
          if (w_rd_load) begin
            r_rdata <= w_ram_rdata;
          end
        end
        ST_RDATA: begin
          r_rdata <= {{BYTE_W{1'b0}}, r_rdata[WORD_W-1:BYTE_W]};
          r_beat  <= r_beat + 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

  word_ram #(
    .DEPTH(DEPTH),
    .IDX_W(IDX_W)
  ) u_word_ram (
    .clk    (clk),
    .i_we   (w_ram_we),
    .i_idx  (w_ram_idx),
    .i_wdata(r_wdata),
    .o_rdata(w_ram_rdata)
  );

endmodule

// File: tb/tb_byte_serial_mem.sv
// tb/tb_byte_serial_mem.sv - self-checking bench for byte_serial_mem at latencies 2, 1 and 15
module tb_byte_serial_mem;

  localparam int LAT0 = 2;
  localparam int LAT1 = 1;
  localparam int LAT2 = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [2:0]      rd_s;
  logic [2:0]      wr_s;
  logic [7:0]      addr_b;
  logic [7:0]      wdata_b;
  logic [2:0][7:0] rdata_w;
  logic [2:0]      ready_w;
  logic [2:0]      busy_w;

  byte_serial_mem #(.DEPTH(256), .LATENCY(LAT0)) u_mem0 (
    .clk(clk), .rst(rst), .ReadMem(rd_s[0]), .WriteMem(wr_s[0]), .Addr(addr_b), .wData(wdata_b),
    .rData(rdata_w[0]), .Ready(ready_w[0]), .Busy(busy_w[0]));
  byte_serial_mem #(.DEPTH(256), .LATENCY(LAT1)) u_mem1 (
    .clk(clk), .rst(rst), .ReadMem(rd_s[1]), .WriteMem(wr_s[1]), .Addr(addr_b), .wData(wdata_b),
    .rData(rdata_w[1]), .Ready(ready_w[1]), .Busy(busy_w[1]));
  byte_serial_mem #(.DEPTH(256), .LATENCY(LAT2)) u_mem2 (
    .clk(clk), .rst(rst), .ReadMem(rd_s[2]), .WriteMem(wr_s[2]), .Addr(addr_b), .wData(wdata_b),
    .rData(rdata_w[2]), .Ready(ready_w[2]), .Busy(busy_w[2]));

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] model [int];

  int          obs_ready_cyc;
  int          obs_ready_cnt;
  logic [31:0] obs_word;
  logic [7:0]  obs_stray;
  logic        obs_busy_c0;
  logic        obs_busy_mid;
  logic [7:0]  obs_pre_rdata;
  logic        obs_abort_busy;
  logic        obs_abort_ready;
  logic [7:0]  obs_abort_rdata;
  logic        obs_idle_busy;
  logic        obs_idle_ready;

  function automatic int lat_of(input int k);
    case (k)
      0:       return LAT0;
      1:       return LAT1;
      default: return LAT2;
    endcase
  endfunction

  function automatic int key(input int k, input logic [31:0] a);
    return k * 1024 + int'((a >> 2) % 256);
  endfunction

  // Called just after a rising edge; cycle 0 is the cycle presenting the strobe.
  task automatic run_txn(input int k, input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdat, input bit toggle, input int abort_cyc);
    int L;
    int last;
    L = lat_of(k);
    last = (abort_cyc >= 0) ? abort_cyc : 8 + L;
    obs_ready_cyc = -1;
    obs_ready_cnt = 0;
    obs_word = '0;
    obs_stray = '0;
    obs_busy_mid = 1'b1;
    obs_busy_c0 = 1'b1;
    for (int c = 0; c <= last; c++) begin
      rd_s = '0;
      wr_s = '0;
      if (c == 0) begin
        rd_s[k] = rd;
        wr_s[k] = wr;
      end else if (toggle) begin
        rd_s[k] = 1'($urandom);
        wr_s[k] = 1'($urandom);
      end
      addr_b  = (c <= 3) ? addr[8*c +: 8] : 8'($urandom);
      wdata_b = (c >= 4 && c <= 7) ? wdat[8*(c-4) +: 8] : 8'($urandom);
      if (c == abort_cyc) begin
        #1;
        obs_pre_rdata = rdata_w[k];
        rst = 1'b0;
        #1;
        obs_abort_busy  = busy_w[k];
        obs_abort_ready = ready_w[k];
        obs_abort_rdata = rdata_w[k];
        @(posedge clk);
        #1;
        rst = 1'b1;
      end else begin
        @(negedge clk);
        if (ready_w[k]) begin
          obs_ready_cnt++;
          if (obs_ready_cyc < 0) obs_ready_cyc = c;
        end
        if (c >= 4 + L && c <= 7 + L) obs_word[8*(c-4-L) +: 8] = rdata_w[k];
        else obs_stray |= rdata_w[k];
        if (c == 0) obs_busy_c0 = busy_w[k];
        else if (!busy_w[k]) obs_busy_mid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    rd_s = '0;
    wr_s = '0;
    if (abort_cyc < 0 && wr) model[key(k, addr)] = wdat;
  endtask

  task automatic idle_sample(input int k);
    @(negedge clk);
    obs_idle_busy  = busy_w[k];
    obs_idle_ready = ready_w[k];
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (busy_w !== 3'b000) begin n_errors++; $display("FAIL reset_busy: got %b expected 000", busy_w); end
    n_checks++; if (ready_w !== 3'b000) begin n_errors++; $display("FAIL reset_ready: got %b expected 000", ready_w); end
    n_checks++; if (rdata_w !== 24'h0) begin n_errors++; $display("FAIL reset_rdata: got %h expected 000000", rdata_w); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    run_txn(0, 0, 1, 32'h0000_0040, 32'hC35A_A53C, 0, -1);
    run_txn(0, 1, 0, 32'h0000_0040, 32'h0, 0, 5);
    n_checks++; if (obs_abort_busy !== 1'b0) begin n_errors++; $display("FAIL abort5_busy: got %b expected 0", obs_abort_busy); end
    n_checks++; if (obs_abort_ready !== 1'b0) begin n_errors++; $display("FAIL abort5_ready: got %b expected 0", obs_abort_ready); end
    idle_sample(0);
    n_checks++; if (obs_idle_busy !== 1'b0) begin n_errors++; $display("FAIL abort5_idle_busy: got %b expected 0", obs_idle_busy); end
    run_txn(0, 1, 0, 32'h0000_0040, 32'h0, 0, 7);
    n_checks++; if (obs_pre_rdata !== 8'hA5) begin n_errors++; $display("FAIL abort7_pre_rdata: got %h expected a5", obs_pre_rdata); end
    n_checks++; if (obs_abort_rdata !== 8'h00) begin n_errors++; $display("FAIL abort7_rdata: got %h expected 00", obs_abort_rdata); end
    run_txn(0, 1, 0, 32'h0000_0040, 32'h0, 0, -1);
    n_checks++; if (obs_ready_cyc !== 10) begin n_errors++; $display("FAIL post_reset_ready_cyc: got %0d expected 10", obs_ready_cyc); end
    n_checks++; if (obs_word !== 32'hC35A_A53C) begin n_errors++; $display("FAIL post_reset_word: got %h expected c35aa53c", obs_word); end
  endtask

  task automatic test_write_read();
    run_txn(0, 0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 0, -1);
    n_checks++; if (obs_ready_cyc !== 10) begin n_errors++; $display("FAIL wr_ready_cyc: got %0d expected 10", obs_ready_cyc); end
    n_checks++; if (obs_ready_cnt !== 1) begin n_errors++; $display("FAIL wr_ready_cnt: got %0d expected 1", obs_ready_cnt); end
    n_checks++; if ((obs_stray | obs_word[7:0] | obs_word[31:8]) !== 0) begin n_errors++; $display("FAIL wr_rdata_quiet: got %h/%h expected 0", obs_stray, obs_word); end
    n_checks++; if (obs_busy_c0 !== 1'b0 || obs_busy_mid !== 1'b1) begin n_errors++; $display("FAIL wr_busy: got c0=%b mid=%b expected 0/1", obs_busy_c0, obs_busy_mid); end
    idle_sample(0);
    n_checks++; if (obs_idle_busy !== 1'b0) begin n_errors++; $display("FAIL wr_idle_busy: got %b expected 0", obs_idle_busy); end
    run_txn(0, 1, 0, 32'h0000_0010, 32'h0, 0, -1);
    n_checks++; if (obs_ready_cyc !== 10) begin n_errors++; $display("FAIL rd_ready_cyc: got %0d expected 10", obs_ready_cyc); end
    n_checks++; if (obs_word !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL rd_bytes: got %h expected deadbeef", obs_word); end
    n_checks++; if (obs_stray !== 8'h00) begin n_errors++; $display("FAIL rd_stray: got %h expected 00", obs_stray); end
  endtask

  task automatic test_wrap();
    run_txn(0, 0, 1, 32'h0000_0404, 32'h1234_5678, 0, -1);
    run_txn(0, 1, 0, 32'h0000_0004, 32'h0, 0, -1);
    n_checks++; if (obs_word !== 32'h1234_5678) begin n_errors++; $display("FAIL wrap_word: got %h expected 12345678", obs_word); end
  endtask

  task automatic test_priority();
    logic [31:0] a;
    logic [31:0] d;
    a = $urandom;
    d = $urandom;
    run_txn(0, 0, 1, a, ~d, 0, -1);
    run_txn(0, 1, 1, a, d, 0, -1);
    n_checks++; if (obs_stray !== 8'h00 || obs_word !== 32'h0) begin n_errors++; $display("FAIL prio_rdata_quiet: got %h/%h expected 0", obs_stray, obs_word); end
    run_txn(0, 1, 0, a, 32'h0, 0, -1);
    n_checks++; if (obs_word !== d) begin n_errors++; $display("FAIL prio_write_done: got %h expected %h", obs_word, d); end
  endtask

  task automatic test_ignore();
    logic [31:0] a;
    logic [31:0] d;
    run_txn(0, 1, 0, 32'h0000_0010, 32'h0, 1, -1);
    n_checks++; if (obs_ready_cnt !== 1 || obs_ready_cyc !== 10) begin n_errors++; $display("FAIL ign_rd_ready: got cnt=%0d cyc=%0d expected 1/10", obs_ready_cnt, obs_ready_cyc); end
    n_checks++; if (obs_word !== model[key(0, 32'h10)]) begin n_errors++; $display("FAIL ign_rd_word: got %h expected %h", obs_word, model[key(0, 32'h10)]); end
    idle_sample(0);
    n_checks++; if (obs_idle_busy !== 1'b0 || obs_idle_ready !== 1'b0) begin n_errors++; $display("FAIL ign_rd_idle: got busy=%b ready=%b expected 0/0", obs_idle_busy, obs_idle_ready); end
    a = $urandom;
    d = $urandom;
    run_txn(1, 0, 1, a, d, 1, -1);
    n_checks++; if (obs_ready_cnt !== 1) begin n_errors++; $display("FAIL ign_wr_ready_cnt: got %0d expected 1", obs_ready_cnt); end
    idle_sample(1);
    n_checks++; if (obs_idle_busy !== 1'b0) begin n_errors++; $display("FAIL ign_wr_idle: got %b expected 0", obs_idle_busy); end
  endtask

  task automatic test_aborted_write();
    run_txn(0, 0, 1, 32'h0000_0020, 32'hAAAA_AAAA, 0, -1);
    run_txn(0, 0, 1, 32'h0000_0020, 32'h5555_5555, 0, 6);
    n_checks++; if (obs_abort_busy !== 1'b0) begin n_errors++; $display("FAIL abortw_busy: got %b expected 0", obs_abort_busy); end
    run_txn(0, 1, 0, 32'h0000_0020, 32'h0, 0, -1);
    n_checks++; if (obs_word !== 32'hAAAA_AAAA) begin n_errors++; $display("FAIL abortw_word: got %h expected aaaaaaaa", obs_word); end
  endtask

  task automatic test_latency_sweep();
    logic [31:0] a;
    logic [31:0] d;
    int exp_cyc;
    for (int k = 1; k <= 2; k++) begin
      exp_cyc = (k == 1) ? 9 : 23;
      a = $urandom;
      d = $urandom;
      run_txn(k, 0, 1, a, d, 0, -1);
      n_checks++; if (obs_ready_cyc !== exp_cyc) begin n_errors++; $display("FAIL lat_wr_ready_cyc k=%0d: got %0d expected %0d", k, obs_ready_cyc, exp_cyc); end
      run_txn(k, 1, 0, a, 32'h0, 0, -1);
      n_checks++; if (obs_ready_cyc !== exp_cyc) begin n_errors++; $display("FAIL lat_rd_ready_cyc k=%0d: got %0d expected %0d", k, obs_ready_cyc, exp_cyc); end
      n_checks++; if (obs_word !== d) begin n_errors++; $display("FAIL lat_rd_word k=%0d: got %h expected %h", k, obs_word, d); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] d;
    for (int k = 0; k <= 1; k++) begin
      a = $urandom;
      d = $urandom;
      run_txn(k, 0, 1, a, d, 0, -1);
      run_txn(k, 1, 0, a, 32'h0, 0, -1);
      n_checks++; if (obs_ready_cyc !== 8 + lat_of(k) || obs_ready_cnt !== 1) begin n_errors++; $display("FAIL b2b_ready k=%0d: got cyc=%0d cnt=%0d expected %0d/1", k, obs_ready_cyc, obs_ready_cnt, 8 + lat_of(k)); end
      n_checks++; if (obs_word !== d) begin n_errors++; $display("FAIL b2b_word k=%0d: got %h expected %h", k, obs_word, d); end
    end
  endtask

  task automatic test_random();
    logic [7:0]  pool [6];
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_word;
    bit          wr;
    int          k;
    for (int i = 0; i < 6; i++) pool[i] = 8'($urandom);
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 2);
      a = {22'($urandom), pool[$urandom_range(0, 5)], 2'($urandom)};
      d = $urandom;
      wr = !model.exists(key(k, a)) || ($urandom_range(0, 1) == 1);
      exp_word = wr ? 32'h0 : model[key(k, a)];
      run_txn(k, !wr, wr, a, d, $urandom_range(0, 3) == 0, -1);
      n_checks++; if (obs_ready_cyc !== 8 + lat_of(k) || obs_ready_cnt !== 1) begin n_errors++; $display("FAIL rnd_ready i=%0d: got cyc=%0d cnt=%0d expected %0d/1", i, obs_ready_cyc, obs_ready_cnt, 8 + lat_of(k)); end
      n_checks++; if (obs_word !== exp_word || obs_stray !== 8'h00) begin n_errors++; $display("FAIL rnd_data i=%0d: got %h stray %h expected %h", i, obs_word, obs_stray, exp_word); end
    end
  endtask

  initial begin
    rst = 1'b0;
    rd_s = '0;
    wr_s = '0;
    addr_b = '0;
    wdata_b = '0;
    test_reset();
    test_write_read();
    test_wrap();
    test_priority();
    test_ignore();
    test_aborted_write();
    test_latency_sweep();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
